// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for input-conditioning blocks.
// clog2 is usable in parameter defaults of any counter block.
package debounce_pkg;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous level into clk.
// All stages reset to 0.
module sync_chain import debounce_pkg::*; #(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ff <= '0;
      else        ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw level, then requires DEBOUNCE_CYCLES consecutive
// mismatching samples before the clean output follows; emits rise/fall strobes.
module debounce_sync import debounce_pkg::*; #(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   logic [CNT_W-1:0] cnt;

   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (s)
   );

   // Any sample equal to dout restarts qualification from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         dout <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= s;
            rise <= s;
            fall <= ~s;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized + directed bench for debounce_sync: a window-based reference
// model feeds an expectation queue that a negedge monitor drains.
module tb_debounce_sync;

   localparam int NS  = 2;
   localparam int DC  = 4;
   localparam int LAT = NS + DC;

   typedef struct packed {
      logic dout;
      logic rise;
      logic fall;
      logic busy;
   } obs_t;

   logic clk;
   logic reset;
   logic din;
   logic dout, rise, fall, busy;

   int vectors    = 0;
   int miscompares = 0;
   int edge_cnt   = 0;

   obs_t exp_q[$];
   logic sync_m[$];
   logic win_m[$];
   logic dout_m;

   debounce_sync #(.SYNC_STAGES(NS), .DEBOUNCE_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .dout  (dout),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic model_clear();
      sync_m.delete();
      for (int i = 0; i < NS; i++) sync_m.push_back(1'b0);
      win_m.delete();
      dout_m = 1'b0;
   endtask

   // Reference: s is din delayed NS edges; dout flips once the last DC
   // samples of s all differ from it.
   initial begin
      obs_t e;
      logic s;
      logic all_diff;
      model_clear();
      forever begin
         @(posedge clk);
         e = '0;
         if (!reset) begin
            model_clear();
         end else begin
            s = sync_m.pop_front();
            sync_m.push_back(din);
            win_m.push_back(s);
            if (win_m.size() > DC) void'(win_m.pop_front());
            all_diff = (win_m.size() == DC);
            foreach (win_m[i]) if (win_m[i] == dout_m) all_diff = 1'b0;
            if (all_diff) begin
               dout_m = s;
               e.rise = s;
               e.fall = ~s;
            end
            e.busy = (s != dout_m);
         end
         e.dout = dout_m;
         exp_q.push_back(e);
      end
   end

   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({dout, rise, fall, busy} !== e) begin
               miscompares++;
               $display("FAIL scoreboard t=%0t got dout=%b rise=%b fall=%b busy=%b want dout=%b rise=%b fall=%b busy=%b",
                        $time, dout, rise, fall, busy, e.dout, e.rise, e.fall, e.busy);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Waits (bounded) for dout to reach v and checks edges elapsed since start.
   task automatic wait_dout(input logic v, input int start, input int exp_n, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (dout === v) seen = 1'b1;
      end
      #1;
      if (!seen) chk({name, "_timeout"}, 0, 1);
      else       chk(name, edge_cnt - start, exp_n);
   endtask

   initial begin
      int start;
      int busy_cnt;
      int run;
      logic lvl;

      // Reset held with din high
      reset = 1'b0;
      din   = 1'b1;
      #1;
      chk("reset_dout", int'(dout), 0);
      chk("reset_busy", int'(busy), 0);
      step(2);

      // Release with din low, idle
      reset = 1'b1;
      din   = 1'b0;
      step(4);

      // Clean rise
      din = 1'b1;
      start = edge_cnt;
      wait_dout(1'b1, start, LAT, "clean_rise_latency");
      step(3);

      // Clean fall
      din = 1'b0;
      start = edge_cnt;
      wait_dout(1'b0, start, LAT, "clean_fall_latency");
      step(3);

      // Glitch of DC-1 synchronized cycles
      busy_cnt = 0;
      din = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i == DC - 1) din = 1'b0;
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         #1;
      end
      chk("glitch_busy_cycles", busy_cnt, DC - 1);
      chk("glitch_dout", int'(dout), 0);

      // Exactly DC cycles passes; fall follows DC edges after the rise
      din = 1'b1;
      start = edge_cnt;
      step(DC);
      din = 1'b0;
      wait_dout(1'b1, start, LAT, "boundary_rise");
      wait_dout(1'b0, start, LAT + DC, "boundary_fall");
      step(4);

      // Reset mid-qualification (counter = 2 after edge 4)
      din = 1'b1;
      step(4);
      chk("midq_busy_before", int'(busy), 1);
      reset = 1'b0;
      #1;
      chk("midq_busy_async", int'(busy), 0);
      chk("midq_dout_async", int'(dout), 0);
      step(2);
      reset = 1'b1;
      start = edge_cnt;
      wait_dout(1'b1, start, LAT, "release_rise");
      step(3);

      // Toggling every cycle: dout must hold
      lvl = dout;
      for (int i = 0; i < 20; i++) begin
         din = ~din;
         step(1);
      end
      chk("toggle_hold", int'(dout), int'(lvl));
      step(8);

      // Random runs with occasional reset pulses
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b0;
            step($urandom_range(1, 2));
            reset = 1'b1;
         end
         din = 1'($urandom_range(0, 1));
         run = $urandom_range(1, 2 * DC);
         step(run);
      end
      step(LAT + 2);

      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
